irq_priority_ctrl: RTL and testbench

Sequencing controller for the external IRQ inputs: latches per-source detection pulses from the `IRQ_function` instances into the interrupt status register (ISR), arbitrates among enabled pending sources by fixed priority, and issues exactly one service request at a time. A request goes either to the CPU exception logic or to the DTC, selected per source. Sits between the per-pin `IRQ_function` instances and the CPU/DTC request interface.

---
 rtl/irq_pkg.sv | 15 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_priority_ctrl.sv | 108 ++++++++++
 tb/tb_irq_priority_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and limits for the IRQ sequencing controller.
package irq_pkg;

    localparam int N_IRQ_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CPU_REQ,
        CPU_SVC,
        DTC_REQ,
        DTC_WAIT
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of cand wins.
module irq_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    cand,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        valid = |cand;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// External IRQ sequencer: latches detections into the ISR, arbitrates by fixed
// priority and issues one CPU exception or DTC transfer request at a time.
module irq_priority_ctrl #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_det,
    input  logic [N_IRQ-1:0] ier,
    input  logic [N_IRQ-1:0] dtce,
    input  logic             cpu_mask,
    input  logic             wren_isr,
    input  logic [N_IRQ-1:0] isr_wdata,
    input  logic             cpu_ack,
    input  logic             cpu_done,
    input  logic             dtc_ack,
    input  logic             dtc_done,
    output logic [N_IRQ-1:0] isr_q,
    output logic             cpu_irq,
    output logic             dtc_req,
    output logic [ID_W-1:0]  svc_id,
    output logic             busy
);

    import irq_pkg::*;

    if (N_IRQ < 2 || N_IRQ > N_IRQ_MAX) begin : g_bad_n_irq
        $error("irq_priority_ctrl: N_IRQ out of range");
    end

    irq_state_e       state;
    irq_state_e       state_next;
    logic [N_IRQ-1:0] isr_next;
    logic [N_IRQ-1:0] wr_clr;
    logic [N_IRQ-1:0] dtc_clr;
    logic [N_IRQ-1:0] cand;
    logic             cand_valid;
    logic [ID_W-1:0]  win_idx;
    logic             still_pending;

    // Detection beats any clear landing on the same bit in the same cycle.
    assign wr_clr   = wren_isr ? ~isr_wdata : '0;
    assign dtc_clr  = (state == DTC_WAIT && dtc_done) ? (N_IRQ'(1) << svc_id) : '0;
    assign isr_next = irq_det | (isr_q & ~wr_clr & ~dtc_clr);

    // The CPU mask only hides CPU-routed sources; DTC-routed ones stay eligible.
    assign cand          = isr_q & ier & (dtce | {N_IRQ{~cpu_mask}});
    assign still_pending = isr_q[svc_id] & ier[svc_id];

    irq_prio_enc #(
        .N    (N_IRQ),
        .ID_W (ID_W)
    ) u_prio_enc (
        .cand  (cand),
        .valid (cand_valid),
        .idx   (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            isr_q  <= '0;
            svc_id <= '0;
        end else begin
            state <= state_next;
            isr_q <= isr_next;
            if (state == ARB && cand_valid) begin
                svc_id <= win_idx;
            end
        end
    end

    // Route is frozen at ARB; an ack in the same cycle as a withdrawal still wins.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cand_valid) state_next = ARB;
            end
            ARB: begin
                if (!cand_valid)         state_next = IDLE;
                else if (dtce[win_idx])  state_next = DTC_REQ;
                else                     state_next = CPU_REQ;
            end
            CPU_REQ: begin
                if (cpu_ack)             state_next = CPU_SVC;
                else if (!still_pending) state_next = IDLE;
            end
            CPU_SVC: begin
                if (cpu_done) state_next = IDLE;
            end
            DTC_REQ: begin
                if (dtc_ack)             state_next = DTC_WAIT;
                else if (!still_pending) state_next = IDLE;
            end
            DTC_WAIT: begin
                if (dtc_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_irq = (state == CPU_REQ);
    assign dtc_req = (state == DTC_REQ);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_irq_priority_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_det, ier, dtce, isr_wdata;
    logic       cpu_mask, wren_isr, cpu_ack, cpu_done, dtc_ack, dtc_done;
    logic [7:0] isr_q;
    logic       cpu_irq, dtc_req, busy;
    logic [2:0] svc_id;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 idle, 1 arbitrating, 2 requesting, 3 in service.
    logic [7:0] m_isr   = '0;
    int         m_phase = 0;
    int         m_id    = 0;
    bit         m_dtc   = 1'b0;

    irq_priority_ctrl #(.N_IRQ(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_det   (irq_det),
        .ier       (ier),
        .dtce      (dtce),
        .cpu_mask  (cpu_mask),
        .wren_isr  (wren_isr),
        .isr_wdata (isr_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_done  (cpu_done),
        .dtc_ack   (dtc_ack),
        .dtc_done  (dtc_done),
        .isr_q     (isr_q),
        .cpu_irq   (cpu_irq),
        .dtc_req   (dtc_req),
        .svc_id    (svc_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [7:0] c;
        logic [7:0] nisr;
        int w;
        c = m_isr & ier & (cpu_mask ? dtce : 8'hFF);
        w = -1;
        for (int i = 7; i >= 0; i--) if (c[i]) w = i;
        for (int i = 0; i < 8; i++) begin
            if (irq_det[i]) nisr[i] = 1'b1;
            else if ((wren_isr && !isr_wdata[i]) ||
                     (m_phase == 3 && m_dtc && dtc_done && m_id == i)) nisr[i] = 1'b0;
            else nisr[i] = m_isr[i];
        end
        if (rst) begin
            m_isr = '0; m_phase = 0; m_id = 0; m_dtc = 1'b0;
            return;
        end
        case (m_phase)
            0: if (w >= 0) m_phase = 1;
            1: begin
                if (w < 0) m_phase = 0;
                else begin m_id = w; m_dtc = dtce[w]; m_phase = 2; end
            end
            2: begin
                if (m_dtc ? dtc_ack : cpu_ack) m_phase = 3;
                else if (!(m_isr[m_id] && ier[m_id])) m_phase = 0;
            end
            3: if (m_dtc ? dtc_done : cpu_done) m_phase = 0;
            default: m_phase = 0;
        endcase
        m_isr = nisr;
    endtask

    // Advance one edge; inputs are driven and outputs sampled at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_det = 8'hFF; ier = 8'hFF; dtce = '0; cpu_mask = 1'b0;
        wren_isr = 1'b0; isr_wdata = '0; cpu_ack = 1'b0; cpu_done = 1'b0;
        dtc_ack = 1'b0; dtc_done = 1'b0;
        cycle(); cycle();
        n_checks++; if (isr_q !== 8'h00) $display("[TB] FAIL reset_isr: got %h want 00", isr_q); else n_pass++;
        n_checks++; if ({cpu_irq, dtc_req, busy} !== 3'b000) $display("[TB] FAIL reset_outs: got %b want 000", {cpu_irq, dtc_req, busy}); else n_pass++;
        n_checks++; if (svc_id !== 3'd0) $display("[TB] FAIL reset_svc_id: got %0d want 0", svc_id); else n_pass++;
        rst = 1'b0; irq_det = '0; ier = '0;
        cycle();
    endtask

    task automatic test_cpu_basic();
        ier = 8'h08; dtce = '0; cpu_mask = 1'b0;
        irq_det = 8'h08; cycle(); irq_det = '0;
        n_checks++; if (isr_q !== 8'h08) $display("[TB] FAIL cpu_isr_set: got %h want 08", isr_q); else n_pass++;
        cycle();
        n_checks++; if ({busy, cpu_irq} !== 2'b10) $display("[TB] FAIL cpu_arb: busy,cpu_irq got %b want 10", {busy, cpu_irq}); else n_pass++;
        cycle();
        n_checks++; if (cpu_irq !== 1'b1 || svc_id !== 3'd3) $display("[TB] FAIL cpu_req: cpu_irq=%b svc_id=%0d want 1/3", cpu_irq, svc_id); else n_pass++;
        cpu_ack = 1'b1; cycle(); cpu_ack = 1'b0;
        n_checks++; if ({busy, cpu_irq} !== 2'b10) $display("[TB] FAIL cpu_svc: busy,cpu_irq got %b want 10", {busy, cpu_irq}); else n_pass++;
        wren_isr = 1'b1; isr_wdata = 8'hF7; cycle(); wren_isr = 1'b0;
        n_checks++; if (isr_q !== 8'h00 || busy !== 1'b1) $display("[TB] FAIL cpu_clear: isr=%h busy=%b want 00/1", isr_q, busy); else n_pass++;
        cpu_done = 1'b1; cycle(); cpu_done = 1'b0;
        cycle();
        n_checks++; if (busy !== 1'b0 || isr_q !== 8'h00) $display("[TB] FAIL cpu_done: busy=%b isr=%h want 0/00", busy, isr_q); else n_pass++;
    endtask

    task automatic test_simultaneous();
        ier = 8'hFF; dtce = '0; cpu_mask = 1'b0;
        irq_det = 8'h24; cycle(); irq_det = '0;
        cycle(); cycle();
        n_checks++; if (cpu_irq !== 1'b1 || svc_id !== 3'd2) $display("[TB] FAIL prio_first: cpu_irq=%b svc_id=%0d want 1/2", cpu_irq, svc_id); else n_pass++;
        cpu_ack = 1'b1; cycle(); cpu_ack = 1'b0;
        wren_isr = 1'b1; isr_wdata = 8'hFB; cycle(); wren_isr = 1'b0;
        cpu_done = 1'b1; cycle(); cpu_done = 1'b0;
        cycle(); cycle();
        n_checks++; if (cpu_irq !== 1'b1 || svc_id !== 3'd5 || isr_q !== 8'h20) $display("[TB] FAIL prio_second: cpu_irq=%b svc_id=%0d isr=%h want 1/5/20", cpu_irq, svc_id, isr_q); else n_pass++;
        cpu_ack = 1'b1; cycle(); cpu_ack = 1'b0;
        wren_isr = 1'b1; isr_wdata = 8'hDF; cycle(); wren_isr = 1'b0;
        cpu_done = 1'b1; cycle(); cpu_done = 1'b0;
        cycle();
    endtask

    task automatic test_dtc();
        ier = 8'hFF; dtce = 8'h02; cpu_mask = 1'b0;
        irq_det = 8'h02; cycle(); irq_det = '0;
        cycle(); cycle();
        n_checks++; if (dtc_req !== 1'b1 || cpu_irq !== 1'b0 || svc_id !== 3'd1) $display("[TB] FAIL dtc_req: dtc=%b cpu=%b svc_id=%0d want 1/0/1", dtc_req, cpu_irq, svc_id); else n_pass++;
        dtc_ack = 1'b1; cycle(); dtc_ack = 1'b0;
        cycle();
        n_checks++; if ({busy, dtc_req, isr_q[1]} !== 3'b101) $display("[TB] FAIL dtc_wait: busy,dtc_req,isr1 got %b want 101", {busy, dtc_req, isr_q[1]}); else n_pass++;
        dtc_done = 1'b1; cycle(); dtc_done = 1'b0;
        n_checks++; if (isr_q !== 8'h00 || busy !== 1'b0 || cpu_irq !== 1'b0) $display("[TB] FAIL dtc_done: isr=%h busy=%b cpu=%b want 00/0/0", isr_q, busy, cpu_irq); else n_pass++;
        cycle();
    endtask

    task automatic test_mask();
        ier = 8'hFF; dtce = 8'h10; cpu_mask = 1'b1;
        irq_det = 8'h11; cycle(); irq_det = '0;
        cycle(); cycle();
        n_checks++; if (dtc_req !== 1'b1 || cpu_irq !== 1'b0 || svc_id !== 3'd4) $display("[TB] FAIL mask_dtc: dtc=%b cpu=%b svc_id=%0d want 1/0/4", dtc_req, cpu_irq, svc_id); else n_pass++;
        dtc_ack = 1'b1; cycle(); dtc_ack = 1'b0;
        dtc_done = 1'b1; cycle(); dtc_done = 1'b0;
        cycle(); cycle();
        n_checks++; if (busy !== 1'b0 || isr_q !== 8'h01) $display("[TB] FAIL mask_block: busy=%b isr=%h want 0/01", busy, isr_q); else n_pass++;
        cpu_mask = 1'b0; cycle(); cycle();
        n_checks++; if (cpu_irq !== 1'b1 || svc_id !== 3'd0) $display("[TB] FAIL mask_release: cpu=%b svc_id=%0d want 1/0", cpu_irq, svc_id); else n_pass++;
        cpu_ack = 1'b1; wren_isr = 1'b1; isr_wdata = 8'hFE; cycle();
        cpu_ack = 1'b0; wren_isr = 1'b0;
        cpu_done = 1'b1; cycle(); cpu_done = 1'b0;
        cycle();
    endtask

    task automatic test_withdraw();
        ier = 8'hFF; dtce = '0; cpu_mask = 1'b0;
        irq_det = 8'h40; cycle(); irq_det = '0;
        cycle(); cycle();
        n_checks++; if (cpu_irq !== 1'b1 || svc_id !== 3'd6) $display("[TB] FAIL wd_req: cpu=%b svc_id=%0d want 1/6", cpu_irq, svc_id); else n_pass++;
        wren_isr = 1'b1; isr_wdata = 8'hBF; cycle(); wren_isr = 1'b0;
        cycle();
        n_checks++; if ({cpu_irq, busy} !== 2'b00 || isr_q !== 8'h00) $display("[TB] FAIL wd_drop: cpu,busy=%b isr=%h want 00/00", {cpu_irq, busy}, isr_q); else n_pass++;
        irq_det = 8'h08; wren_isr = 1'b1; isr_wdata = 8'hF7; cycle();
        irq_det = '0; wren_isr = 1'b0;
        n_checks++; if (isr_q !== 8'h08) $display("[TB] FAIL set_beats_clear: got %h want 08", isr_q); else n_pass++;
        cycle(); cycle();
        cpu_ack = 1'b1; wren_isr = 1'b1; isr_wdata = 8'hF7; cycle();
        cpu_ack = 1'b0; wren_isr = 1'b0;
        cpu_done = 1'b1; cycle(); cpu_done = 1'b0;
        cycle();
    endtask

    task automatic test_reset_in_flight();
        ier = 8'hFF; dtce = 8'h02; cpu_mask = 1'b0;
        irq_det = 8'h02; cycle(); irq_det = '0;
        cycle(); cycle();
        dtc_ack = 1'b1; cycle(); dtc_ack = 1'b0;
        rst = 1'b1; cycle(); rst = 1'b0;
        n_checks++; if ({cpu_irq, dtc_req, busy} !== 3'b000 || isr_q !== 8'h00 || svc_id !== 3'd0) $display("[TB] FAIL rst_flight: outs=%b isr=%h svc_id=%0d want 000/00/0", {cpu_irq, dtc_req, busy}, isr_q, svc_id); else n_pass++;
        dtc_done = 1'b1; cycle(); dtc_done = 1'b0;
        n_checks++; if (busy !== 1'b0 || isr_q !== 8'h00) $display("[TB] FAIL stray_done: busy=%b isr=%h want 0/00", busy, isr_q); else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = ($urandom_range(299) == 0);
            irq_det   = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(15) == 0) ier  = 8'($urandom);
            if ($urandom_range(15) == 0) dtce = 8'($urandom);
            if ($urandom_range(31) == 0) cpu_mask = ~cpu_mask;
            wren_isr  = ($urandom_range(5) == 0);
            isr_wdata = 8'($urandom);
            cpu_ack   = ($urandom_range(3) == 0);
            cpu_done  = ($urandom_range(3) == 0);
            dtc_ack   = ($urandom_range(3) == 0);
            dtc_done  = ($urandom_range(3) == 0);
            cycle();
            n_checks++; if (isr_q !== m_isr) begin errs++; $display("[TB] FAIL rnd_isr @%0d: got %h want %h", cyc, isr_q, m_isr); end else n_pass++;
            n_checks++; if (cpu_irq !== (m_phase == 2 && !m_dtc)) begin errs++; $display("[TB] FAIL rnd_cpu_irq @%0d: got %b want %b", cyc, cpu_irq, (m_phase == 2 && !m_dtc)); end else n_pass++;
            n_checks++; if (dtc_req !== (m_phase == 2 && m_dtc)) begin errs++; $display("[TB] FAIL rnd_dtc_req @%0d: got %b want %b", cyc, dtc_req, (m_phase == 2 && m_dtc)); end else n_pass++;
            n_checks++; if (busy !== (m_phase != 0)) begin errs++; $display("[TB] FAIL rnd_busy @%0d: got %b want %b", cyc, busy, (m_phase != 0)); end else n_pass++;
            n_checks++; if (svc_id !== 3'(m_id)) begin errs++; $display("[TB] FAIL rnd_svc_id @%0d: got %0d want %0d", cyc, svc_id, m_id); end else n_pass++;
            if (errs > 20) break;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_basic();
        test_simultaneous();
        test_dtc();
        test_mask();
        test_withdraw();
        test_reset_in_flight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
